// File: rtl/rgb_to_grayscale_pkg.sv
// Shared constants and types for the RGB-to-luma adapter.
// Build option: RGB_TO_GRAYSCALE_ROUND_EN selects round-to-nearest instead of truncation.
package rgb_to_grayscale_pkg;

  localparam int unsigned COEF_R     = 32'd77;
  localparam int unsigned COEF_G     = 32'd150;
  localparam int unsigned COEF_B     = 32'd29;
  localparam int unsigned LUMA_SHIFT = 32'd8;

`ifdef RGB_TO_GRAYSCALE_ROUND_EN
  localparam int unsigned ROUND_C = 32'd128;
`else
  localparam int unsigned ROUND_C = 32'd0;
`endif

  typedef struct packed {
    logic last;
    logic user;
    logic dest;
    logic id;
  } sideband_t;

  function automatic int unsigned round_up8(input int unsigned bits);
    return ((bits + 32'd7) / 32'd8) * 32'd8;
  endfunction

endpackage

// File: rtl/rgb_to_grayscale_luma.sv
// Three-stage luma datapath: products, sum (+ rounding constant), shift.
// Build option: RGB_TO_GRAYSCALE_ROUND_EN (via ROUND_C in the package).
module rgb_to_grayscale_luma
  import rgb_to_grayscale_pkg::*;
#(
  parameter int unsigned PX_WIDTH       = 10,
  parameter int unsigned RX_TDATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en1,
  input  logic                      en2,
  input  logic                      en3,
  input  logic [RX_TDATA_WIDTH-1:0] tdata,
  output logic [PX_WIDTH-1:0]       luma
);

  localparam int unsigned PROD_W = PX_WIDTH + 32'd8;
  localparam int unsigned SUM_W  = PX_WIDTH + 32'd9;

  logic [PX_WIDTH-1:0] g_s;
  logic [PX_WIDTH-1:0] b_s;
  logic [PX_WIDTH-1:0] r_s;
  logic [PROD_W-1:0]   prod_r_r;
  logic [PROD_W-1:0]   prod_g_r;
  logic [PROD_W-1:0]   prod_b_r;
  logic [SUM_W-1:0]    sum_r;
  logic [PX_WIDTH-1:0] luma_r;
  logic                unused_s;

  assign g_s = tdata[PX_WIDTH-1:0];
  assign b_s = tdata[2*PX_WIDTH-1:PX_WIDTH];
  assign r_s = tdata[3*PX_WIDTH-1:2*PX_WIDTH];

  // Coefficients sum to 256, so the sum MSB is never set and padding bits are don't-care.
  assign unused_s = ^{tdata, sum_r[SUM_W-1]};

  // Stage registers, each advancing only on its own enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_r <= '0;
      prod_g_r <= '0;
      prod_b_r <= '0;
      sum_r    <= '0;
      luma_r   <= '0;
    end else begin
      if (en1) begin
        prod_r_r <= PROD_W'(r_s) * PROD_W'(COEF_R);
        prod_g_r <= PROD_W'(g_s) * PROD_W'(COEF_G);
        prod_b_r <= PROD_W'(b_s) * PROD_W'(COEF_B);
      end
      if (en2) begin
        sum_r <= SUM_W'(prod_r_r) + SUM_W'(prod_g_r) + SUM_W'(prod_b_r) + SUM_W'(ROUND_C);
      end
      if (en3) begin
        luma_r <= sum_r[LUMA_SHIFT +: PX_WIDTH];
      end
    end
  end

  assign luma = luma_r;

endmodule

// File: rtl/rgb_to_grayscale_adapter.sv
// AXI4-Stream RGB to grayscale adapter: valid/ready chain, sideband pipe, strobe/keep.
// Build option: RGB_TO_GRAYSCALE_ROUND_EN enables round-to-nearest luma.
module rgb_to_grayscale_adapter
  import rgb_to_grayscale_pkg::*;
#(
  parameter int unsigned PX_WIDTH         = 10,
  parameter int unsigned RX_TDATA_WIDTH   = round_up8(3 * PX_WIDTH),
  parameter int unsigned TX_TDATA_WIDTH   = round_up8(PX_WIDTH),
  parameter int unsigned RX_TDATA_WIDTH_B = RX_TDATA_WIDTH / 32'd8,
  parameter int unsigned TX_TDATA_WIDTH_B = TX_TDATA_WIDTH / 32'd8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        video_i_tvalid,
  output logic                        video_i_tready,
  input  logic [RX_TDATA_WIDTH-1:0]   video_i_tdata,
  input  logic                        video_i_tlast,
  input  logic                        video_i_tuser,
  input  logic                        video_i_tdest,
  input  logic                        video_i_tid,
  input  logic [RX_TDATA_WIDTH_B-1:0] video_i_tstrb,
  input  logic [RX_TDATA_WIDTH_B-1:0] video_i_tkeep,
  output logic                        video_o_tvalid,
  input  logic                        video_o_tready,
  output logic [TX_TDATA_WIDTH-1:0]   video_o_tdata,
  output logic                        video_o_tlast,
  output logic                        video_o_tuser,
  output logic                        video_o_tdest,
  output logic                        video_o_tid,
  output logic [TX_TDATA_WIDTH_B-1:0] video_o_tstrb,
  output logic [TX_TDATA_WIDTH_B-1:0] video_o_tkeep
);

  logic                v1_r, v2_r, v3_r;
  logic                ready1_s, ready2_s, ready3_s;
  sideband_t           sb_in_s, sb1_r, sb2_r, sb3_r;
  logic [PX_WIDTH-1:0] luma_s;
  logic                unused_s;

  assign unused_s = ^{video_i_tstrb, video_i_tkeep};
  assign sb_in_s  = {video_i_tlast, video_i_tuser, video_i_tdest, video_i_tid};

  // Ready chain: an empty stage always accepts, so bubbles collapse under stall.
  always_comb begin
    ready3_s = !v3_r || video_o_tready;
    ready2_s = !v2_r || ready3_s;
    ready1_s = !v1_r || ready2_s;
  end

  // Valid bits and sideband advance in lockstep with the datapath enables.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
      v3_r  <= 1'b0;
      sb1_r <= '0;
      sb2_r <= '0;
      sb3_r <= '0;
    end else begin
      if (ready1_s) begin
        v1_r <= video_i_tvalid;
        if (video_i_tvalid) sb1_r <= sb_in_s;
      end
      if (ready2_s) begin
        v2_r <= v1_r;
        if (v1_r) sb2_r <= sb1_r;
      end
      if (ready3_s) begin
        v3_r <= v2_r;
        if (v2_r) sb3_r <= sb2_r;
      end
    end
  end

  rgb_to_grayscale_luma #(
    .PX_WIDTH       (PX_WIDTH),
    .RX_TDATA_WIDTH (RX_TDATA_WIDTH)
  ) u_luma (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en1   (ready1_s && video_i_tvalid),
    .en2   (ready2_s && v1_r),
    .en3   (ready3_s && v2_r),
    .tdata (video_i_tdata),
    .luma  (luma_s)
  );

  // Zero-extend luma into the byte-aligned output word.
  always_comb begin
    video_o_tdata                = '0;
    video_o_tdata[PX_WIDTH-1:0]  = luma_s;
  end

  assign video_i_tready = ready1_s;
  assign video_o_tvalid = v3_r;
  assign video_o_tlast  = sb3_r.last;
  assign video_o_tuser  = sb3_r.user;
  assign video_o_tdest  = sb3_r.dest;
  assign video_o_tid    = sb3_r.id;
  assign video_o_tstrb  = {TX_TDATA_WIDTH_B{v3_r}};
  assign video_o_tkeep  = {TX_TDATA_WIDTH_B{v3_r}};

endmodule

// File: tb/tb_rgb_to_grayscale_adapter.sv
// Scoreboard bench for rgb_to_grayscale_adapter (P=10); honours RGB_TO_GRAYSCALE_ROUND_EN.
module tb_rgb_to_grayscale_adapter;

`ifdef RGB_TO_GRAYSCALE_ROUND_EN
  localparam int RC = 128;
  localparam logic [9:0] EXP_PRI [5] = '{10'd1023, 10'd308, 10'd599, 10'd116, 10'd0};
`else
  localparam int RC = 0;
  localparam logic [9:0] EXP_PRI [5] = '{10'd1023, 10'd307, 10'd599, 10'd115, 10'd0};
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vi_tvalid = 1'b0, vi_tready;
  logic [31:0] vi_tdata = '0;
  logic        vi_tlast = 1'b0, vi_tuser = 1'b0, vi_tdest = 1'b0, vi_tid = 1'b0;
  logic        vo_tvalid, vo_tready = 1'b1;
  logic [15:0] vo_tdata;
  logic        vo_tlast, vo_tuser, vo_tdest, vo_tid;
  logic [1:0]  vo_tstrb, vo_tkeep;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;

  always #5 clk = ~clk;

  rgb_to_grayscale_adapter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .video_i_tvalid(vi_tvalid), .video_i_tready(vi_tready), .video_i_tdata(vi_tdata),
    .video_i_tlast(vi_tlast), .video_i_tuser(vi_tuser), .video_i_tdest(vi_tdest),
    .video_i_tid(vi_tid), .video_i_tstrb(4'hF), .video_i_tkeep(4'hF),
    .video_o_tvalid(vo_tvalid), .video_o_tready(vo_tready), .video_o_tdata(vo_tdata),
    .video_o_tlast(vo_tlast), .video_o_tuser(vo_tuser), .video_o_tdest(vo_tdest),
    .video_o_tid(vo_tid), .video_o_tstrb(vo_tstrb), .video_o_tkeep(vo_tkeep)
  );

  function automatic logic [31:0] pack(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    return {2'b11, r, b, g};
  endfunction

  // Reference: Y = (77R + 150G + 29B + RC) / 256, followed by sideband and strb/keep all ones.
  function automatic logic [23:0] model(input logic [31:0] d, input logic [3:0] sb);
    logic [31:0] y;
    y = (32'd77 * 32'(d[29:20]) + 32'd150 * 32'(d[9:0]) + 32'd29 * 32'(d[19:10]) + 32'(RC)) >> 8;
    return {6'b0, y[9:0], sb, 2'b11, 2'b11};
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (vo_tvalid && vo_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_beat got=%h", vo_tdata);
        end else begin
          exp_e = exp_q.pop_front();
          if ({vo_tdata, vo_tlast, vo_tuser, vo_tdest, vo_tid, vo_tstrb, vo_tkeep} !== exp_e) begin
            n_err++;
            $display("FAIL sb_beat got=%h want=%h", {vo_tdata, vo_tlast, vo_tuser, vo_tdest, vo_tid,
                     vo_tstrb, vo_tkeep}, exp_e);
          end
        end
      end
      if (vi_tvalid && vi_tready)
        exp_q.push_back(model(vi_tdata, {vi_tlast, vi_tuser, vi_tdest, vi_tid}));
    end
  end

  task automatic drain();
    vi_tvalid = 1'b0;
    vo_tready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (vo_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b want=0", vo_tvalid); end
    n_vec++;
    if ({vo_tdata, vo_tlast, vo_tuser, vo_tdest, vo_tid, vo_tstrb, vo_tkeep} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h want=0", {vo_tdata, vo_tlast, vo_tuser, vo_tdest, vo_tid,
               vo_tstrb, vo_tkeep});
    end
    n_vec++;
    if (vi_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready got=%b want=1", vi_tready); end
    rst_n = 1'b1;
  endtask

  task automatic test_primary();
    logic [9:0] rgb [5][3];
    rgb = '{'{10'd1023, 10'd1023, 10'd1023}, '{10'd1023, 10'd0, 10'd0},
            '{10'd0, 10'd1023, 10'd0}, '{10'd0, 10'd0, 10'd1023}, '{10'd0, 10'd0, 10'd0}};
    vo_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int  k;
      bit  seen;
      vi_tdata  = pack(rgb[i][0], rgb[i][1], rgb[i][2]);
      vi_tvalid = 1'b1;
      vi_tlast  = i[0];
      vi_tuser  = (i == 0);
      vi_tdest  = i[1];
      vi_tid    = 1'b1;
      @(posedge clk); #1;
      vi_tvalid = 1'b0;
      seen = 1'b0;
      k    = 0;
      for (int c = 1; c <= 6 && !seen; c++) begin
        @(posedge clk); #1;
        if (vo_tvalid) begin seen = 1'b1; k = c; end
      end
      n_vec++;
      if (!seen || vo_tdata !== {6'b0, EXP_PRI[i]}) begin
        n_err++;
        $display("FAIL primary_y[%0d] got=%0d want=%0d seen=%0b", i, vo_tdata, EXP_PRI[i], seen);
      end
      n_vec++;
      if (k + 1 != 3) begin n_err++; $display("FAIL primary_latency[%0d] got=%0d want=3", i, k + 1); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, cnt = 0, first = -1, last = -1;
    vo_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vi_tdata  = pack(10'(c * 131), 10'(c * 77 + 3), 10'(c * 201));
      vi_tvalid = 1'b1;
      {vi_tlast, vi_tuser, vi_tdest, vi_tid} = 4'(c);
      @(negedge clk);
      if (vi_tvalid && vi_tready) acc++;
      if (vo_tvalid) begin cnt++; if (first < 0) first = c; last = c; end
      @(posedge clk); #1;
    end
    vi_tvalid = 1'b0;
    for (int c = 8; c < 14; c++) begin
      @(negedge clk);
      if (vo_tvalid) begin cnt++; if (first < 0) first = c; last = c; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (acc != 8) begin n_err++; $display("FAIL b2b_accepted got=%0d want=8", acc); end
    n_vec++;
    if (cnt != 8 || last - first != 7) begin
      n_err++;
      $display("FAIL b2b_out_contiguous got=%0d span=%0d want=8 span=7", cnt, last - first);
    end
  endtask

  task automatic test_random_bp();
    int idx = 0, cycles = 0;
    vi_tvalid = 1'b1;
    while (idx < 512 && cycles < 6000) begin
      vi_tdata = {2'b00, 10'(idx * 37), 10'(idx * 113 + 7), 10'(idx * 59 + 5)};
      vi_tlast = (idx % 64 == 63);
      vi_tuser = (idx % 256 == 0);
      vi_tdest = idx[3];
      vi_tid   = idx[4];
      vo_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (vi_tready) idx++;
      @(posedge clk); #1;
      cycles++;
    end
    n_vec++;
    if (idx != 512) begin n_err++; $display("FAIL random_bp_timeout got=%0d want=512", idx); end
    drain();
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL random_bp_drain left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_full_stall();
    int acc = 0, cnt = 0, first = -1, last = -1;
    vo_tready = 1'b0;
    vi_tvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vi_tdata = pack(10'(acc * 300 + 1), 10'(acc * 150 + 2), 10'(acc * 90 + 3));
      {vi_tlast, vi_tuser, vi_tdest, vi_tid} = 4'(acc * 5 + 3);
      @(negedge clk);
      if (vi_tready) acc++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (acc != 3) begin n_err++; $display("FAIL stall_accepted got=%0d want=3", acc); end
    n_vec++;
    if (vi_tready !== 1'b0) begin n_err++; $display("FAIL stall_tready got=%b want=0", vi_tready); end
    vi_tvalid = 1'b0;
    vo_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (vo_tvalid) begin cnt++; if (first < 0) first = c; last = c; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (cnt != 3 || first != 0 || last != 2) begin
      n_err++;
      $display("FAIL stall_drain got=%0d first=%0d last=%0d want=3 first=0 last=2", cnt, first, last);
    end
  endtask

  task automatic test_bubbles();
    int acc = 0;
    vo_tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      vi_tvalid = (c % 2 == 0);
      vi_tdata  = pack(10'(acc * 400 + 11), 10'(acc * 250 + 22), 10'(acc * 170 + 33));
      {vi_tlast, vi_tuser, vi_tdest, vi_tid} = 4'(acc * 6 + 9);
      @(negedge clk);
      if (vi_tvalid && vi_tready) acc++;
      @(posedge clk); #1;
    end
    vi_tvalid = 1'b0;
    n_vec++;
    if (acc != 3) begin n_err++; $display("FAIL bubble_accepted got=%0d want=3", acc); end
    n_vec++;
    if (vi_tready !== 1'b0 || vo_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL bubble_full got tready=%b tvalid=%b want 0/1", vi_tready, vo_tvalid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    vo_tready = 1'b1;
    vi_tvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      vi_tdata = pack(10'(c * 500 + 5), 10'(c * 10 + 1), 10'd7);
      {vi_tlast, vi_tuser, vi_tdest, vi_tid} = 4'hF;
      @(posedge clk); #1;
    end
    vi_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (vo_tvalid !== 1'b0 || vo_tkeep !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_outputs got tvalid=%b tkeep=%b want 0/00", vo_tvalid, vo_tkeep);
    end
    n_vec++;
    if (vi_tready !== 1'b1) begin n_err++; $display("FAIL midreset_tready got=%b want=1", vi_tready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vo_tvalid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL midreset_stale got=1 want=0"); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_primary();
    test_back_to_back();
    test_random_bp();
    test_full_stall();
    test_bubbles();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
